// File: rtl/rgb_pwm_pkg.sv
// Shared types for the RGB fade controller: FSM state encoding and default field width.
package rgb_pwm_pkg;

    localparam int W_DEF = 16;

    typedef enum logic {
        IDLE = 1'b0,
        FADE = 1'b1
    } fade_state_t;

endpackage

// File: rtl/rgb_fade_step.sv
// One channel's move toward its target: min(step, |target-current|), or a direct jump when step is 0.
module rgb_fade_step
    import rgb_pwm_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0] cur,
    input  logic [W-1:0] tgt,
    input  logic [W-1:0] step,
    output logic [W-1:0] nxt
);

    logic         up;
    logic [W-1:0] diff;

    // Only add/subtract when the distance exceeds the step, so the result never wraps.
    always_comb begin
        up   = (tgt > cur);
        diff = up ? (tgt - cur) : (cur - tgt);
        nxt  = tgt;
        if ((step != '0) && (diff > step)) begin
            nxt = up ? (cur + step) : (cur - step);
        end
    end

endmodule

// File: rtl/rgb_fade_ctrl.sv
// RGB fade controller: shared PWM period counter plus an IDLE/FADE sequencer stepping three duties.
// Optional one-cycle done pulse on FADE->IDLE when RGB_FADE_DONE_EN is defined.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// FADE  | stepping duties toward targets on each period_tick
module rgb_fade_ctrl
    import rgb_pwm_pkg::*;
#(
    parameter int           W          = W_DEF,
    parameter logic [W-1:0] MAXCNT_RST = 16'd1000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [W-1:0] cmd_r,
    input  logic [W-1:0] cmd_g,
    input  logic [W-1:0] cmd_b,
    input  logic [W-1:0] cmd_step,
    input  logic [W-1:0] cmd_countmax,
    output logic [W-1:0] countmax,
    output logic [W-1:0] r_hi,
    output logic [W-1:0] g_hi,
    output logic [W-1:0] b_hi,
    output logic         period_tick,
    output logic         busy
`ifdef RGB_FADE_DONE_EN
    ,
    output logic         done
`endif
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    fade_state_t  state;
    logic [W-1:0] cnt;
    logic [W-1:0] last;
    logic [W-1:0] tgt_r, tgt_g, tgt_b, step_q;
    logic [W-1:0] r_nxt, g_nxt, b_nxt;
    logic         at_tgt;

    // A period of 0 behaves as 1, so the tick fires every cycle.
    assign last        = (countmax == '0) ? '0 : (countmax - ONE);
    assign period_tick = (cnt == last);
    assign at_tgt      = (r_hi == tgt_r) && (g_hi == tgt_g) && (b_hi == tgt_b);

    rgb_fade_step #(.W(W)) u_step_r (.cur(r_hi), .tgt(tgt_r), .step(step_q), .nxt(r_nxt));
    rgb_fade_step #(.W(W)) u_step_g (.cur(g_hi), .tgt(tgt_g), .step(step_q), .nxt(g_nxt));
    rgb_fade_step #(.W(W)) u_step_b (.cur(b_hi), .tgt(tgt_b), .step(step_q), .nxt(b_nxt));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            countmax  <= MAXCNT_RST;
            r_hi      <= '0;
            g_hi      <= '0;
            b_hi      <= '0;
            tgt_r     <= '0;
            tgt_g     <= '0;
            tgt_b     <= '0;
            step_q    <= '0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
`ifdef RGB_FADE_DONE_EN
            done      <= 1'b0;
`endif
        end else begin
`ifdef RGB_FADE_DONE_EN
            done <= 1'b0;
`endif
            cnt <= (cnt >= last) ? '0 : (cnt + ONE);
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        tgt_r     <= cmd_r;
                        tgt_g     <= cmd_g;
                        tgt_b     <= cmd_b;
                        step_q    <= cmd_step;
                        countmax  <= cmd_countmax;
                        cnt       <= '0;
                        state     <= FADE;
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                    end
                end
                FADE: begin
                    if (at_tgt) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
`ifdef RGB_FADE_DONE_EN
                        done      <= 1'b1;
`endif
                    end else if (period_tick) begin
                        // Duties only move at the period boundary.
                        r_hi <= r_nxt;
                        g_hi <= g_nxt;
                        b_hi <= b_nxt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rgb_fade_ctrl.sv
// Bench for rgb_fade_ctrl: scenario tasks checked against a per-tick fade model derived from the stepping rules.
module tb_rgb_fade_ctrl;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [W-1:0] cmd_r = '0, cmd_g = '0, cmd_b = '0, cmd_step = '0, cmd_countmax = '0;
    logic [W-1:0] countmax, r_hi, g_hi, b_hi;
    logic         period_tick, busy;
`ifdef RGB_FADE_DONE_EN
    logic         done;
`endif

    rgb_fade_ctrl #(.W(W), .MAXCNT_RST(16'd1000)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_r(cmd_r), .cmd_g(cmd_g), .cmd_b(cmd_b), .cmd_step(cmd_step),
        .cmd_countmax(cmd_countmax), .countmax(countmax),
        .r_hi(r_hi), .g_hi(g_hi), .b_hi(b_hi),
        .period_tick(period_tick), .busy(busy)
`ifdef RGB_FADE_DONE_EN
        , .done(done)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int m_r = 0, m_g = 0, m_b = 0;
    int m_eff = 1;
    int acc_cyc = 0;

    function automatic int step_toward(input int cur, input int tgt, input int s);
        int d;
        d = tgt - cur;
        if (s == 0 || (d <= s && d >= -s)) return tgt;
        return (d > 0) ? cur + s : cur - s;
    endfunction

    // Issue one command and check every cycle until the first IDLE cycle.
    task automatic do_fade(input int tr, input int tg, input int tb_, input int st, input int cm);
        int sr[0:1023];
        int sg[0:1023];
        int sb[0:1023];
        int n, eff, end_rel, k;
        bit exp_tick, exp_busy;
        eff = (cm == 0) ? 1 : cm;
        sr[0] = m_r; sg[0] = m_g; sb[0] = m_b;
        n = 0;
        while ((sr[n] != tr || sg[n] != tg || sb[n] != tb_) && n < 1023) begin
            sr[n+1] = step_toward(sr[n], tr, st);
            sg[n+1] = step_toward(sg[n], tg, st);
            sb[n+1] = step_toward(sb[n], tb_, st);
            n++;
        end
        end_rel = n * eff;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL fade_ready_before_cmd: got %b want 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_r = W'(tr); cmd_g = W'(tg); cmd_b = W'(tb_); cmd_step = W'(st); cmd_countmax = W'(cm);
        @(negedge clk);
        cmd_valid = 1'b0;
        acc_cyc = cyc;
        m_eff = eff;
        checks++;
        if (countmax !== W'(cm)) begin
            failures++;
            $display("FAIL fade_countmax_load: got %0d want %0d", countmax, cm);
        end
        for (int rel = 0; rel <= end_rel + 1; rel++) begin
            if (rel > 0) @(negedge clk);
            k = rel / eff;
            if (k > n) k = n;
            exp_tick = ((rel % eff) == eff - 1);
            exp_busy = (rel <= end_rel);
            checks++;
            if (period_tick !== exp_tick) begin
                failures++;
                $display("FAIL fade_tick rel=%0d: got %b want %b", rel, period_tick, exp_tick);
            end
            checks++;
            if (r_hi !== W'(sr[k]) || g_hi !== W'(sg[k]) || b_hi !== W'(sb[k])) begin
                failures++;
                $display("FAIL fade_hi rel=%0d: got %0d/%0d/%0d want %0d/%0d/%0d",
                         rel, r_hi, g_hi, b_hi, sr[k], sg[k], sb[k]);
            end
            checks++;
            if (busy !== exp_busy || cmd_ready !== !exp_busy) begin
                failures++;
                $display("FAIL fade_busy rel=%0d: got busy=%b ready=%b want busy=%b", rel, busy, cmd_ready, exp_busy);
            end
`ifdef RGB_FADE_DONE_EN
            checks++;
            if (done !== (rel == end_rel + 1)) begin
                failures++;
                $display("FAIL fade_done rel=%0d: got %b want %b", rel, done, (rel == end_rel + 1));
            end
`endif
        end
        m_r = tr; m_g = tg; m_b = tb_;
    endtask

    task automatic idle_check(input int ncyc);
        int rel;
        bit exp_tick;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            rel = cyc - acc_cyc;
            exp_tick = ((rel % m_eff) == m_eff - 1);
            checks++;
            if (period_tick !== exp_tick || busy !== 1'b0 || cmd_ready !== 1'b1 ||
                r_hi !== W'(m_r) || g_hi !== W'(m_g) || b_hi !== W'(m_b)) begin
                failures++;
                $display("FAIL idle rel=%0d: got tick=%b busy=%b ready=%b hi=%0d/%0d/%0d want tick=%b hi=%0d/%0d/%0d",
                         rel, period_tick, busy, cmd_ready, r_hi, g_hi, b_hi, exp_tick, m_r, m_g, m_b);
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (r_hi !== '0 || g_hi !== '0 || b_hi !== '0 || busy !== 1'b0 || cmd_ready !== 1'b1 ||
            countmax !== 16'd1000 || period_tick !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got hi=%0d/%0d/%0d busy=%b ready=%b cm=%0d tick=%b want 0/0/0 0 1 1000 0",
                     r_hi, g_hi, b_hi, busy, cmd_ready, countmax, period_tick);
        end
        m_r = 0; m_g = 0; m_b = 0;
        do_fade(0, 0, 0, 1, 4);
        idle_check(12);
    endtask

    task automatic test_fade_up;
        do_fade(10, 3, 0, 4, 8);
    endtask

    task automatic test_fade_down;
        do_fade(1, 3, 0, 4, 8);
    endtask

    task automatic test_jump;
        do_fade(100, 200, 300, 0, 5);
        idle_check(6);
    endtask

    task automatic test_random;
        for (int i = 0; i < 6; i++) begin
            do_fade(int'($urandom_range(0, 60)), int'($urandom_range(0, 60)), int'($urandom_range(0, 60)),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 5)));
        end
    endtask

    task automatic test_boundary;
        do_fade(65535, 0, 65535, 40000, 2);
        do_fade(0, 65535, 7, 40000, 3);
    endtask

    task automatic test_hold;
        bit seen_idle;
        cmd_valid = 1'b1;
        cmd_r = 16'd5; cmd_g = 16'd5; cmd_b = 16'd5; cmd_step = '0; cmd_countmax = 16'd3;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL hold_accept_a: got busy=%b want 1", busy);
        end
        cmd_r = 16'd7; cmd_g = 16'd8; cmd_b = 16'd9; cmd_countmax = 16'd5;
        seen_idle = 1'b0;
        for (int i = 0; i < 40 && !seen_idle; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                seen_idle = 1'b1;
            end else begin
                checks++;
                if (cmd_ready !== 1'b0 || countmax !== 16'd3) begin
                    failures++;
                    $display("FAIL hold_ignored: got ready=%b cm=%0d want 0 3", cmd_ready, countmax);
                end
            end
        end
        checks++;
        if (!seen_idle || r_hi !== 16'd5 || g_hi !== 16'd5 || b_hi !== 16'd5 ||
            countmax !== 16'd3 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL hold_end_a: got idle=%b hi=%0d/%0d/%0d cm=%0d ready=%b want 1 5/5/5 3 1",
                     seen_idle, r_hi, g_hi, b_hi, countmax, cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || countmax !== 16'd5) begin
            failures++;
            $display("FAIL hold_accept_b: got busy=%b cm=%0d want 1 5", busy, countmax);
        end
        seen_idle = 1'b0;
        for (int i = 0; i < 40 && !seen_idle; i++) begin
            @(negedge clk);
            if (busy === 1'b0) seen_idle = 1'b1;
        end
        checks++;
        if (!seen_idle || r_hi !== 16'd7 || g_hi !== 16'd8 || b_hi !== 16'd9) begin
            failures++;
            $display("FAIL hold_end_b: got idle=%b hi=%0d/%0d/%0d want 1 7/8/9", seen_idle, r_hi, g_hi, b_hi);
        end
        m_r = 7; m_g = 8; m_b = 9;
    endtask

    task automatic test_reset_mid;
        cmd_valid = 1'b1;
        cmd_r = 16'd50; cmd_g = 16'd50; cmd_b = 16'd50; cmd_step = 16'd1; cmd_countmax = 16'd3;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (7) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL midreset_busy_before: got %b want 1", busy);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (r_hi !== '0 || g_hi !== '0 || b_hi !== '0 || busy !== 1'b0 || cmd_ready !== 1'b1 ||
            countmax !== 16'd1000) begin
            failures++;
            $display("FAIL midreset_state: got hi=%0d/%0d/%0d busy=%b ready=%b cm=%0d want 0/0/0 0 1 1000",
                     r_hi, g_hi, b_hi, busy, cmd_ready, countmax);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (busy !== 1'b0 || period_tick !== 1'b0
`ifdef RGB_FADE_DONE_EN
                || done !== 1'b0
`endif
               ) begin
                failures++;
                $display("FAIL midreset_quiet cycle=%0d: got busy=%b tick=%b want 0 0", i, busy, period_tick);
            end
            @(negedge clk);
        end
        m_r = 0; m_g = 0; m_b = 0;
    endtask

    task automatic test_countmax_zero;
        do_fade(3, 3, 3, 1, 0);
        idle_check(8);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_fade_up;
        test_fade_down;
        test_jump;
        test_random;
        test_hold;
        test_boundary;
        test_reset_mid;
        test_countmax_zero;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rgb_fade_ctrl.md
RGB_FADE_CTRL -- requirements
Module: rgb_fade_ctrl

Interface
REQ-001 SHALL have parameter W, default 16, meaning width of every count, duty and step field.
REQ-002 SHALL have parameter MAXCNT_RST, default 16'd1000, meaning the PWM period used until the first command is accepted.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have port clk  input  1  the single clock; all logic is on the posedge.
REQ-005 SHALL have port reset  input  1  synchronous active-high reset.
REQ-006 SHALL have port cmd_valid  input  1  a fade command is offered.
REQ-007 SHALL have port cmd_ready  output  1  a command can be accepted this cycle.
REQ-008 SHALL have port cmd_r, cmd_g, cmd_b  input  W each  target high counts.
REQ-009 SHALL have port cmd_step  input  W  maximum change per channel per PWM period.
REQ-010 SHALL have port cmd_countmax  input  W  PWM period for this command.
REQ-011 SHALL have port countmax  output  W  shared period driven to the three PWM channels.
REQ-012 SHALL have port r_hi, g_hi, b_hi  output  W each  current high counts driven to the PWM channels.
REQ-013 SHALL have port period_tick  output  1  one-cycle pulse at the last count of each period.
REQ-014 SHALL have port busy  output  1  a fade is in progress.

Function
REQ-015 SHALL run a free counter 0..countmax-1, wrap to 0, and pulse period_tick when the counter equals countmax-1.
REQ-016 SHALL treat countmax==0 as 1, giving period_tick every cycle.
REQ-017 SHALL implement two states, IDLE and FADE.
REQ-018 SHALL drive cmd_ready=1 only in IDLE.
REQ-019 SHALL accept a command on cmd_valid&&cmd_ready, latch the targets and step, load countmax from cmd_countmax, reset the period counter to 0, and enter FADE on the next cycle.
REQ-020 SHALL treat cmd_step==0 as a direct jump: all channels equal their targets at the first period_tick.
REQ-021 SHALL, in FADE on each period_tick, move each channel toward its target by min(step,|target-current|), with no overflow or underflow.
REQ-022 SHALL change r_hi/g_hi/b_hi only on the cycle after period_tick, so a period never sees a mid-period duty change.
REQ-023 SHALL return to IDLE on the cycle after all three channels equal their targets; busy=1 exactly while in FADE.
REQ-024 SHALL pass hi values greater than countmax unclamped (the PWM flags no-pulse itself).
REQ-025 SHALL accept a command arriving in the same cycle that FADE ends on the following cycle, not the same one.
REQ-026 SHALL ignore cmd_valid while in FADE; there is no abort.

Reset
REQ-027 SHALL, on reset, set state=IDLE, counter=0, r_hi=g_hi=b_hi=0, countmax=MAXCNT_RST, period_tick=0, busy=0, and cmd_ready=1 on the first cycle after reset.
REQ-028 SHALL, on reset asserted mid-fade, discard the latched command; no done pulse is issued.

Configuration
REQ-029 SHALL recognise the macro RGB_FADE_DONE_EN.
REQ-030 SHALL, when RGB_FADE_DONE_EN is defined, add output port done (1 bit), pulsed for one cycle on the FADE->IDLE transition and held 0 in reset.
REQ-031 SHALL, when RGB_FADE_DONE_EN is undefined, omit the port and its logic, with no other behaviour change.

Structure
REQ-032 SHALL take the state enum (IDLE, FADE) and the default width from shared package rgb_pwm_pkg.
REQ-033 SHALL implement the per-channel step toward target in sub-module rgb_fade_step, instantiated three times.

Verification
REQ-034 SHALL cover: reset, then countmax=4 idle -> period_tick every 4th cycle, hi outputs 0, cmd_ready=1.
REQ-035 SHALL cover: cmd r=10,g=3,b=0, step=4, countmax=8 -> r_hi 4,8,10; g_hi 3,3,3; b_hi 0; busy falls after the 3rd tick; done pulses once when enabled.
REQ-036 SHALL cover: from r=10, cmd r=1, step=4 -> r_hi 6,2,1, with no underflow.
REQ-037 SHALL cover: cmd step=0, targets 100/200/300 -> all reached at the first tick.
REQ-038 SHALL cover: cmd_valid held during FADE -> not accepted until the cycle after busy falls.
REQ-039 SHALL cover: reset pulse mid-fade -> all hi=0, IDLE, no done pulse; countmax=0 -> period_tick held high.
